// File: rtl/io_output_pkg.sv
// Shared address-select constants, status bit positions and the I/O store decoder
// for the memory-mapped output ports.
package io_output_pkg;

    localparam int          NPORT_C     = 3;
    localparam logic [5:0]  IO_OUT0_SEL = 6'b100000;
    localparam logic [5:0]  IO_OUT1_SEL = 6'b100001;
    localparam logic [5:0]  IO_OUT2_SEL = 6'b100010;
    localparam logic [5:0]  IO_STAT_SEL = 6'b100011;
    localparam int          VALID_LSB   = 0;
    localparam int          OVR_LSB     = 4;

    typedef struct packed {
        logic [NPORT_C-1:0] wr;
        logic               stat;
    } io_dec_t;

    // At most one target is selected per store; unmapped selects decode to nothing.
    function automatic io_dec_t io_decode(input logic en, input logic [5:0] sel);
        io_dec_t d;
        d = '0;
        if (en) begin
            unique case (sel)
                IO_OUT0_SEL: d.wr   = 3'b001;
                IO_OUT1_SEL: d.wr   = 3'b010;
                IO_OUT2_SEL: d.wr   = 3'b100;
                IO_STAT_SEL: d.stat = 1'b1;
                default:     d      = '0;
            endcase
        end
        return d;
    endfunction

endpackage

// File: rtl/io_output_chan.sv
// One output channel: data register, valid flag toward the consumer and a sticky
// overrun flag raised when the CPU overwrites data the consumer never took.
module io_output_chan
    import io_output_pkg::*;
#(
    parameter logic [31:0] RST_VAL = 32'h0
) (
    input  logic        io_clk,
    input  logic        clrn,
    input  logic        wr,
    input  logic        ack,
    input  logic        ovr_clr,
    input  logic [31:0] din,
    output logic [31:0] data_o,
    output logic        valid_o,
    output logic        ovr_o
);

    logic [31:0] data_q, data_d;
    logic        valid_q, valid_d;
    logic        ovr_q, ovr_d;
    logic        ovr_set;

    // An ack arriving with the overwriting store means the old item was taken.
    assign ovr_set = wr && valid_q && !ack;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (wr) begin
            data_d  = din;
            valid_d = 1'b1;
        end else if (ack) begin
            valid_d = 1'b0;
        end
        ovr_d = (ovr_q && !ovr_clr) || ovr_set;
    end

    always_ff @(posedge io_clk or negedge clrn) begin
        if (!clrn) begin
            data_q  <= RST_VAL;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign ovr_o   = ovr_q;

endmodule

// File: rtl/io_output.sv
// Memory-mapped output-port block: decodes CPU stores into three output channels
// and a W1C status register reporting pending data and overruns.
module io_output
    import io_output_pkg::*;
#(
    parameter int          NPORT   = NPORT_C,
    parameter logic [31:0] RST_VAL = 32'h0
) (
    input  logic             io_clk,
    input  logic             clrn,
    input  logic [31:0]      addr,
    input  logic [31:0]      datain,
    input  logic             write_io_enable,
    output logic [31:0]      out_port0,
    output logic [31:0]      out_port1,
    output logic [31:0]      out_port2,
    output logic [NPORT-1:0] out_valid,
    input  logic [NPORT-1:0] out_ack,
    output logic [31:0]      status_data
);

    io_dec_t                     dec;
    logic [NPORT-1:0]            ovr;
    logic [NPORT-1:0]            ovr_clr;
    logic [NPORT-1:0][31:0]      port;
    logic                        unused_addr;

    assign unused_addr = ^{addr[31:8], addr[1:0]};

    assign dec     = io_decode(write_io_enable, addr[7:2]);
    assign ovr_clr = dec.stat ? datain[OVR_LSB +: NPORT] : '0;

    for (genvar i = 0; i < NPORT; i++) begin : g_chan
        io_output_chan #(.RST_VAL(RST_VAL)) u_chan (
            .io_clk  (io_clk),
            .clrn    (clrn),
            .wr      (dec.wr[i]),
            .ack     (out_ack[i]),
            .ovr_clr (ovr_clr[i]),
            .din     (datain),
            .data_o  (port[i]),
            .valid_o (out_valid[i]),
            .ovr_o   (ovr[i])
        );
    end

    assign out_port0 = port[0];
    assign out_port1 = port[1];
    assign out_port2 = port[2];

    always_comb begin
        status_data                       = '0;
        status_data[VALID_LSB +: NPORT]   = out_valid;
        status_data[OVR_LSB   +: NPORT]   = ovr;
    end

endmodule

// File: tb/tb_io_output.sv
// Directed bench for io_output: store/ack sequences with hand-computed expectations.
module tb_io_output;

    logic        io_clk = 1'b0;
    logic        clrn   = 1'b0;
    logic [31:0] addr   = '0;
    logic [31:0] datain = '0;
    logic        write_io_enable = 1'b0;
    logic [2:0]  out_ack = '0;
    logic [31:0] out_port0, out_port1, out_port2, status_data;
    logic [2:0]  out_valid;

    int n_chk  = 0;
    int n_pass = 0;

    io_output dut (
        .io_clk          (io_clk),
        .clrn            (clrn),
        .addr            (addr),
        .datain          (datain),
        .write_io_enable (write_io_enable),
        .out_port0       (out_port0),
        .out_port1       (out_port1),
        .out_port2       (out_port2),
        .out_valid       (out_valid),
        .out_ack         (out_ack),
        .status_data     (status_data)
    );

    always #5 io_clk = ~io_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    endtask

    // One bus cycle: drive at negedge, let the posedge sample, settle #1 after it.
    task automatic bus(input logic we, input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] ack);
        @(negedge io_clk);
        write_io_enable = we;
        addr            = a;
        datain          = d;
        out_ack         = ack;
        @(posedge io_clk);
        #1;
        write_io_enable = 1'b0;
        out_ack         = '0;
    endtask

    initial begin
        #1;
        chk("rst_port0",  out_port0,   32'h0);
        chk("rst_valid",  {29'b0, out_valid}, 32'h0);
        chk("rst_status", status_data, 32'h0);
        @(negedge io_clk);
        clrn = 1'b1;

        bus(1'b1, 32'h84, 32'hDEADBEEF, 3'b000);
        chk("wr1_port1", out_port1, 32'hDEADBEEF);
        chk("wr1_valid", {29'b0, out_valid}, 32'h2);
        bus(1'b0, 32'h0, 32'h0, 3'b010);
        chk("ack1_valid", {29'b0, out_valid}, 32'h0);
        chk("ack1_port1", out_port1, 32'hDEADBEEF);
        chk("ack1_status", status_data, 32'h0);

        bus(1'b1, 32'h80, 32'h1, 3'b000);
        bus(1'b1, 32'h80, 32'h2, 3'b000);
        chk("ovr0_port0", out_port0, 32'h2);
        chk("ovr0_status", status_data, 32'h11);
        bus(1'b1, 32'h8C, 32'h10, 3'b000);
        chk("w1c0_status", status_data, 32'h01);
        chk("w1c0_port0", out_port0, 32'h2);
        bus(1'b0, 32'h0, 32'h0, 3'b001);
        chk("ack0_status", status_data, 32'h0);

        bus(1'b1, 32'h88, 32'h5, 3'b000);
        chk("wr2_status", status_data, 32'h04);
        bus(1'b1, 32'h88, 32'h7, 3'b100);
        chk("wrack2_port2", out_port2, 32'h7);
        chk("wrack2_status", status_data, 32'h04);

        bus(1'b1, 32'hF0, 32'hAAAA, 3'b000);
        bus(1'b1, 32'h90, 32'hBBBB, 3'b000);
        bus(1'b0, 32'h80, 32'hCCCC, 3'b000);
        chk("dec_port0", out_port0, 32'h2);
        chk("dec_port1", out_port1, 32'hDEADBEEF);
        chk("dec_port2", out_port2, 32'h7);
        chk("dec_status", status_data, 32'h04);

        bus(1'b1, 32'h88, 32'h9, 3'b000);
        chk("ovr2_status", status_data, 32'h44);
        // Overrun clear and ack of the same channel in one cycle.
        bus(1'b1, 32'h8C, 32'h40, 3'b100);
        chk("clrack2_status", status_data, 32'h00);
        chk("clrack2_port2", out_port2, 32'h9);

        bus(1'b1, 32'h80, 32'h3, 3'b000);
        chk("wr0_status", status_data, 32'h01);
        bus(1'b1, 32'h80, 32'h4, 3'b000);
        chk("ovr0b_status", status_data, 32'h11);
        // Clearing an unset bit leaves the set overrun bit alone.
        bus(1'b1, 32'h8C, 32'h2F, 3'b000);
        chk("w1c1_status", status_data, 32'h11);
        // Overrun re-arms right after a clear.
        bus(1'b1, 32'h8C, 32'h10, 3'b000);
        bus(1'b1, 32'h80, 32'h5, 3'b000);
        chk("rearm_status", status_data, 32'h11);
        chk("rearm_port0", out_port0, 32'h5);

        bus(1'b1, 32'h84, 32'h12345678, 3'b000);
        @(negedge io_clk);
        #2;
        clrn = 1'b0;
        #1;
        chk("arst_port0",  out_port0,   32'h0);
        chk("arst_port1",  out_port1,   32'h0);
        chk("arst_port2",  out_port2,   32'h0);
        chk("arst_valid",  {29'b0, out_valid}, 32'h0);
        chk("arst_status", status_data, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
